// File: rtl/mod_counter_param.sv
// Parametrised up/down modulo or saturating counter with terminal-count, wrap, saturate and sticky overflow flags.
// Optional input prescaler is compiled in with `define COUNTER_PRESCALE_EN.
module mod_counter_param #(
  parameter int CNT_W     = 7,
  parameter int MAX_VAL   = 100,
  parameter int PRESC_DIV = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dir,
  input  logic             i_mode,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_tc,
  output logic             o_wrap,
  output logic             o_sat,
  output logic             o_ovf
);

  generate
    if (MAX_VAL < 1 || MAX_VAL > (2 ** CNT_W) - 1) begin : g_bad_max
      $fatal(1, "mod_counter_param: MAX_VAL=%0d outside 1..2^CNT_W-1", MAX_VAL);
    end
    if (PRESC_DIV < 1) begin : g_bad_presc
      $fatal(1, "mod_counter_param: PRESC_DIV must be >= 1");
    end
  endgenerate

  localparam logic [CNT_W:0]   MAX_EXT = (CNT_W+1)'(MAX_VAL);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_VAL);

  logic [CNT_W-1:0] cnt;
  logic             wrap;
  logic             ovf;
  logic             tick;
  logic [CNT_W:0]   cnt_up;
  logic [CNT_W:0]   cnt_dn;
  logic             at_top;
  logic             at_bot;

`ifdef COUNTER_PRESCALE_EN
  localparam int PW = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESC_DIV - 1);

  logic [PW-1:0] presc;

  assign tick = (presc == PRESC_LAST);

  // Prescaler phase restarts on clear/load so a loaded value is held a full period.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      presc <= '0;
    else if (i_clr || i_load)
      presc <= '0;
    else if (i_en)
      presc <= tick ? '0 : presc + PW'(1);
  end
`else
  assign tick = 1'b1;
`endif

  assign cnt_up = {1'b0, cnt} + (CNT_W+1)'(1);
  assign cnt_dn = {1'b0, cnt} - (CNT_W+1)'(1);
  assign at_top = ({1'b0, cnt} >= MAX_EXT);
  assign at_bot = (cnt == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt  <= '0;
      wrap <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (i_clr) begin
        cnt <= '0;
        ovf <= 1'b0;
      end else if (i_load) begin
        if ({1'b0, i_load_val} > MAX_EXT) begin
          cnt <= MAX_CNT;
          ovf <= 1'b1;
        end else begin
          cnt <= i_load_val;
        end
      end else if (i_en && tick) begin
        if (i_dir) begin
          if (at_top) begin
            ovf <= 1'b1;
            if (!i_mode) begin
              cnt  <= '0;
              wrap <= 1'b1;
            end
          end else begin
            cnt <= cnt_up[CNT_W-1:0];
          end
        end else begin
          if (at_bot) begin
            ovf <= 1'b1;
            if (!i_mode) begin
              cnt  <= MAX_CNT;
              wrap <= 1'b1;
            end
          end else begin
            cnt <= cnt_dn[CNT_W-1:0];
          end
        end
      end
    end
  end

  assign o_cnt  = cnt;
  assign o_wrap = wrap;
  assign o_ovf  = ovf;
  assign o_tc   = (i_dir && (cnt == MAX_CNT)) || (!i_dir && at_bot);
  assign o_sat  = i_mode && o_tc;

endmodule
